// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter
// Shares one graphics ROM/SDRAM read port among background tile fetch (BG),
// sprite fetch (SPR) and CPU reads. Priority follows the raster phase, a
// saturating wait counter bounds CPU latency, and a tag pipeline routes each
// fixed-latency return to the requester that issued it.
module gfx_rom_arbiter #(
    parameter int AW     = 17,
    parameter int DW     = 16,
    parameter int LAT    = 2,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hb,
    input  logic          vb,
    input  logic          bg_req,
    input  logic [AW-1:0] bg_addr,
    output logic          bg_ack,
    output logic          bg_valid,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    output logic          spr_ack,
    output logic          spr_valid,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [DW-1:0] rd_data,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] OWN_BG  = 2'd0;
    localparam logic [1:0] OWN_SPR = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE);

    logic          elig_bg, elig_spr, elig_cpu;
    logic          gnt_bg, gnt_spr, gnt_cpu, gnt_any;
    logic [AW-1:0] gnt_addr;
    logic [7:0]    cpu_wait;
    logic [1:0]    issue_owner;
    logic          tag_v   [LAT];
    logic [1:0]    tag_own [LAT];
    logic          ret_v;
    logic [1:0]    ret_owner;

    // A requester whose ack is showing may still hold req for this cycle; skip it
    always_comb begin
        elig_bg  = bg_req  && !bg_ack;
        elig_spr = spr_req && !spr_ack;
        elig_cpu = cpu_req && !cpu_ack;
    end

    // Phase-dependent priority select with the CPU starvation override on top
    always_comb begin
        gnt_bg  = 1'b0;
        gnt_spr = 1'b0;
        gnt_cpu = 1'b0;
        if (mem_ready) begin
            if (elig_cpu && (cpu_wait >= STARVE_LIM)) begin
                gnt_cpu = 1'b1;
            end else if (vb) begin
                if (elig_cpu)      gnt_cpu = 1'b1;
                else if (elig_spr) gnt_spr = 1'b1;
                else if (elig_bg)  gnt_bg  = 1'b1;
            end else if (hb) begin
                if (elig_spr)      gnt_spr = 1'b1;
                else if (elig_bg)  gnt_bg  = 1'b1;
                else if (elig_cpu) gnt_cpu = 1'b1;
            end else begin
                if (elig_bg)       gnt_bg  = 1'b1;
                else if (elig_spr) gnt_spr = 1'b1;
                else if (elig_cpu) gnt_cpu = 1'b1;
            end
        end
        gnt_any  = gnt_bg || gnt_spr || gnt_cpu;
        gnt_addr = gnt_cpu ? cpu_addr : (gnt_spr ? spr_addr : bg_addr);
    end

    // Issue register: strobe, address and the winner's ack all appear together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            bg_ack   <= 1'b0;
            spr_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
        end else begin
            mem_req <= gnt_any;
            bg_ack  <= gnt_bg;
            spr_ack <= gnt_spr;
            cpu_ack <= gnt_cpu;
            if (gnt_any) begin
                mem_addr <= gnt_addr;
            end
        end
    end

    // CPU wait counter: saturating, cleared once the CPU has been served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_wait <= 8'd0;
        end else if (cpu_ack) begin
            cpu_wait <= 8'd0;
        end else if (cpu_req && !gnt_cpu && (cpu_wait != 8'hFF)) begin
            cpu_wait <= cpu_wait + 8'd1;
        end
    end

    // Owner of the read currently on the memory strobe
    always_comb begin
        issue_owner = cpu_ack ? OWN_CPU : (spr_ack ? OWN_SPR : OWN_BG);
    end

    // Tag pipeline: the issue register is the head, so the last stage lines up with mem_rdata
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_own[i] <= OWN_BG;
            end
        end else begin
            tag_v[0]   <= mem_req;
            tag_own[0] <= issue_owner;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    // Tail of the tag pipeline, valid while mem_rdata carries the matching read
    always_comb begin
        ret_v     = tag_v[LAT-1];
        ret_owner = tag_own[LAT-1];
    end

    // Return register: capture data and pulse the owner's valid; data holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data   <= '0;
            bg_valid  <= 1'b0;
            spr_valid <= 1'b0;
            cpu_valid <= 1'b0;
        end else begin
            bg_valid  <= ret_v && (ret_owner == OWN_BG);
            spr_valid <= ret_v && (ret_owner == OWN_SPR);
            cpu_valid <= ret_v && (ret_owner == OWN_CPU);
            if (ret_v) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Testbench for gfx_rom_arbiter: a reference model predicts every grant and
// every data return (with its exact cycle) into queues; a negedge monitor pops
// and compares whenever the DUT strobes memory or pulses a valid.
module tb_gfx_rom_arbiter;

    localparam int AW     = 17;
    localparam int DW     = 16;
    localparam int LAT    = 2;
    localparam int STARVE = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          hb = 1'b0, vb = 1'b0;
    logic          bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0;
    logic [AW-1:0] bg_addr = '0, spr_addr = '0, cpu_addr = '0;
    logic          bg_ack, spr_ack, cpu_ack;
    logic          bg_valid, spr_valid, cpu_valid;
    logic [DW-1:0] rd_data;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    gfx_rom_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset), .hb(hb), .vb(vb),
        .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_valid(bg_valid),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_valid(spr_valid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_valid(cpu_valid),
        .rd_data(rd_data), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int own; logic [AW-1:0] addr; } gnt_t;
    typedef struct { int cyc; int own; logic [DW-1:0] data; } ret_t;

    gnt_t gq[$];
    ret_t rq[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int n_gnt = 0;
    int bgv_cnt = 0;

    // requester behaviour (index 0 = BG, 1 = SPR, 2 = CPU)
    bit            req_r  [3];
    logic [AW-1:0] addr_r [3];
    int            keep_pct  [3];
    int            raise_pct [3];
    int            ready_pct = 100;
    bit            rand_phase = 1'b0;

    // reference model state
    bit            eack [3];
    int            ewait = 0;
    logic [DW-1:0] last_rd = '0;

    // memory model
    bit            sched_v [16];
    logic [DW-1:0] sched_d [16];

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_model();
        gq.delete();
        rq.delete();
        ewait = 0;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            eack[i]  = 1'b0;
            req_r[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
    endtask

    // Expected behaviour for the edge closing this cycle, from the priority rules
    task automatic model_step();
        bit elig [3];
        int ord  [3];
        int win;
        win = -1;
        for (int i = 0; i < 3; i++) elig[i] = req_r[i] && !eack[i];
        if (vb)      ord = '{2, 1, 0};
        else if (hb) ord = '{1, 0, 2};
        else         ord = '{0, 1, 2};
        if (mem_ready) begin
            if (ewait >= STARVE && elig[2]) win = 2;
            else begin
                for (int k = 0; k < 3; k++)
                    if (win < 0 && elig[ord[k]]) win = ord[k];
            end
        end
        if (eack[2])                    ewait = 0;
        else if (req_r[2] && win != 2)  ewait = (ewait < 255) ? ewait + 1 : 255;
        for (int i = 0; i < 3; i++) eack[i] = (win == i);
        if (win >= 0) begin
            gq.push_back('{cyc + 1, win, addr_r[win]});
            rq.push_back('{cyc + 2 + LAT, win, addr_r[win][DW-1:0]});
        end
    endtask

    // One clock cycle of stimulus; rst_v holds reset high for this cycle
    task automatic step(input bit rst_v);
        bit dack [3];
        @(posedge clk);
        cyc++;
        #1;
        dack = '{bg_ack, spr_ack, cpu_ack};
        if (rst_v) begin
            reset = 1'b1;
            flush_model();
            mem_ready = 1'b0;
        end else begin
            reset = 1'b0;
            if (sched_v[cyc % 16]) begin
                mem_rdata = sched_d[cyc % 16];
                sched_v[cyc % 16] = 1'b0;
            end else begin
                mem_rdata = DW'($urandom);
            end
            if (mem_req) begin
                sched_v[(cyc + LAT) % 16] = 1'b1;
                sched_d[(cyc + LAT) % 16] = mem_addr[DW-1:0];
            end
            for (int i = 0; i < 3; i++) begin
                if (dack[i]) begin
                    if (int'($urandom_range(99)) < keep_pct[i]) addr_r[i] = AW'($urandom);
                    else req_r[i] = 1'b0;
                end else if (!req_r[i] && int'($urandom_range(99)) < raise_pct[i]) begin
                    req_r[i]  = 1'b1;
                    addr_r[i] = AW'($urandom);
                end
            end
            mem_ready = (int'($urandom_range(99)) < ready_pct);
            if (rand_phase) begin
                if ($urandom_range(99) < 5) hb = ~hb;
                if ($urandom_range(99) < 3) vb = ~vb;
            end
        end
        bg_req  = req_r[0]; bg_addr  = addr_r[0];
        spr_req = req_r[1]; spr_addr = addr_r[1];
        cpu_req = req_r[2]; cpu_addr = addr_r[2];
        if (!rst_v) model_step();
    endtask

    task automatic set_knobs(input int keep, input int raise);
        for (int i = 0; i < 3; i++) begin
            keep_pct[i]  = keep;
            raise_pct[i] = raise;
        end
    endtask

    // Monitor: compares DUT activity against the queued expectations
    gnt_t       mg;
    ret_t       mr;
    logic [2:0] dut_g, dut_v, exp_oh;
    always @(negedge clk) begin
        dut_g = {cpu_ack, spr_ack, bg_ack};
        dut_v = {cpu_valid, spr_valid, bg_valid};
        if (bg_valid) bgv_cnt++;
        if (reset) begin
            chk("reset_outputs", (dut_g == 3'b0) && (dut_v == 3'b0) && !mem_req &&
                (rd_data == '0) && (mem_addr == '0),
                64'({mem_req, dut_g, dut_v}), 64'(0));
        end else begin
            if (mem_req || dut_g != 3'b0) begin
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    mg = gq.pop_front();
                    n_gnt++;
                    exp_oh = 3'b001 << mg.own;
                    chk("grant_owner", mem_req && (dut_g == exp_oh), 64'({mem_req, dut_g}), 64'({1'b1, exp_oh}));
                    chk("grant_addr", mem_addr == mg.addr, 64'(mem_addr), 64'(mg.addr));
                end else begin
                    chk("grant_unexpected", 1'b0, 64'({mem_req, dut_g}), 64'(0));
                end
            end else if (gq.size() > 0 && gq[0].cyc == cyc) begin
                mg = gq.pop_front();
                chk("grant_missing", 1'b0, 64'(0), 64'(3'b001 << mg.own));
            end
            if (dut_v != 3'b0) begin
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    mr = rq.pop_front();
                    exp_oh = 3'b001 << mr.own;
                    chk("valid_owner", dut_v == exp_oh, 64'(dut_v), 64'(exp_oh));
                    chk("valid_data", rd_data == mr.data, 64'(rd_data), 64'(mr.data));
                    last_rd = mr.data;
                end else begin
                    chk("valid_unexpected", 1'b0, 64'(dut_v), 64'(0));
                end
            end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
                mr = rq.pop_front();
                chk("valid_missing", 1'b0, 64'(0), 64'(3'b001 << mr.own));
                last_rd = mr.data;
            end else begin
                chk("rd_data_hold", rd_data == last_rd, 64'(rd_data), 64'(last_rd));
            end
        end
    end

    initial begin
        int c0, ca;
        bit seen;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_r[i] = '0;
            eack[i]   = 1'b0;
        end
        set_knobs(0, 0);
        #1 reset = 1'b1;
        flush_model();
        repeat (3) step(1'b1);

        // reset mid-transfer: reset one cycle after bg_ack, the return must vanish
        req_r[0] = 1'b1; addr_r[0] = 17'h0A5A5;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(1'b0);
            if (bg_ack) seen = 1'b1;
        end
        chk("rst_bg_ack_seen", seen, 64'(seen), 64'(1));
        step(1'b1);
        step(1'b1);
        repeat (8) step(1'b0);
        chk("rst_discard_bg_valid", bgv_cnt == 0, 64'(bgv_cnt), 64'(0));

        // active line: BG then SPR
        hb = 1'b0; vb = 1'b0;
        req_r[0] = 1'b1; addr_r[0] = 17'h00111;
        req_r[1] = 1'b1; addr_r[1] = 17'h00222;
        repeat (8) step(1'b0);

        // horizontal blank: SPR, BG, CPU
        hb = 1'b1;
        req_r[0] = 1'b1; addr_r[0] = 17'h01001;
        req_r[1] = 1'b1; addr_r[1] = 17'h01002;
        req_r[2] = 1'b1; addr_r[2] = 17'h01003;
        repeat (8) step(1'b0);

        // vertical blank: CPU, SPR, BG
        hb = 1'b0; vb = 1'b1;
        req_r[0] = 1'b1; addr_r[0] = 17'h12001;
        req_r[1] = 1'b1; addr_r[1] = 17'h12002;
        req_r[2] = 1'b1; addr_r[2] = 17'h12003;
        repeat (8) step(1'b0);

        // starvation: BG and SPR keep the port busy, CPU must break in after STARVE waits
        vb = 1'b0;
        keep_pct[0] = 100; keep_pct[1] = 100;
        req_r[0] = 1'b1; addr_r[0] = 17'h02000;
        req_r[1] = 1'b1; addr_r[1] = 17'h03000;
        repeat (4) step(1'b0);
        req_r[2] = 1'b1; addr_r[2] = 17'h04444;
        step(1'b0);
        c0 = cyc;
        ca = -1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0);
            if (cpu_ack) begin seen = 1'b1; ca = cyc; end
        end
        chk("starve_latency", seen && (ca - c0 == STARVE + 1), 64'(ca - c0), 64'(STARVE + 1));
        set_knobs(0, 0);
        repeat (6) step(1'b0);

        // backpressure: SPR waits out five cycles of mem_ready=0
        ready_pct = 0;
        req_r[1] = 1'b1; addr_r[1] = 17'h15A5A;
        repeat (5) step(1'b0);
        ready_pct = 100;
        repeat (6) step(1'b0);

        // data routing: BG and CPU alternate on consecutive cycles
        keep_pct[0] = 100; keep_pct[2] = 100;
        req_r[0] = 1'b1; addr_r[0] = 17'h0BEEF;
        req_r[2] = 1'b1; addr_r[2] = 17'h1C0DE;
        repeat (12) step(1'b0);
        set_knobs(0, 0);
        repeat (6) step(1'b0);

        // randomized traffic with phase changes, backpressure and occasional resets
        rand_phase = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (n % 50 == 0) begin
                for (int i = 0; i < 3; i++) begin
                    keep_pct[i]  = int'($urandom_range(100));
                    raise_pct[i] = int'($urandom_range(60));
                end
                ready_pct = int'($urandom_range(100, 40));
            end
            step($urandom_range(999) < 3);
        end
        rand_phase = 1'b0;
        set_knobs(0, 0);
        for (int i = 0; i < 3; i++) req_r[i] = 1'b0;
        ready_pct = 100;
        repeat (LAT + 8) step(1'b0);

        chk("grant_queue_drained", gq.size() == 0, 64'(gq.size()), 64'(0));
        chk("return_queue_drained", rq.size() == 0, 64'(rq.size()), 64'(0));
        chk("traffic_volume", n_gnt > 200, 64'(n_gnt), 64'(201));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
